// File: rtl/spi_ram_pkg.sv
// Shared command codes and FSM state encodings for the SPI-attached RAM controller.
package spi_ram_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RD_FETCH = 2'd1;
  localparam logic [1:0] RD_HOLD  = 2'd2;

endpackage

// File: rtl/sp_ram_core.sv
// Single-port RAM: synchronous write, registered read (one-cycle read latency).
module sp_ram_core #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: no reset on the array or read register so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Decodes 10-bit SPI words into address/data commands against a single-port RAM
// and returns read data to the SPI slave with a valid flag held until the next command.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8,
  parameter bit AUTO_INC  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_SIZE+1:0] din,
  input  logic                 rx_valid,
  output logic [DATA_SIZE-1:0] dout,
  output logic                 tx_valid,
  output logic                 busy
);

  localparam int MEM_AW = $clog2(MEM_DEPTH);

  logic                 rx_valid_d;
  logic [1:0]           state;
  logic [MEM_AW-1:0]    wr_addr;
  logic [MEM_AW-1:0]    rd_addr;
  logic                 pend_valid;
  logic [ADDR_SIZE+1:0] pend_word;

  logic                 accept;
  logic                 exec_valid;
  logic [ADDR_SIZE+1:0] exec_word;
  logic [1:0]           exec_cmd;
  logic [MEM_AW-1:0]    exec_addr;
  logic                 ram_we;
  logic [MEM_AW-1:0]    ram_addr;
  logic [DATA_SIZE-1:0] ram_rdata;

  // Wraps at MEM_DEPTH even when the depth is not a power of two.
  function automatic logic [MEM_AW-1:0] addr_next(input logic [MEM_AW-1:0] a);
    return (a == MEM_AW'(MEM_DEPTH - 1)) ? '0 : a + MEM_AW'(1);
  endfunction

  assign accept = rx_valid & ~rx_valid_d;
  assign busy   = (state == RD_FETCH);

  // A parked word takes priority so commands always execute in arrival order.
  // NOTE: every always_comb output gets a default up front so no latch is inferred.
  always_comb begin
    exec_word  = din;
    exec_valid = 1'b0;
    if (state != RD_FETCH) begin
      exec_word  = pend_valid ? pend_word : din;
      exec_valid = pend_valid | accept;
    end
  end

  assign exec_cmd  = exec_word[ADDR_SIZE+1:ADDR_SIZE];
  assign exec_addr = exec_word[MEM_AW-1:0];
  assign ram_we    = exec_valid && (exec_cmd == CMD_WR_DATA);
  assign ram_addr  = ram_we ? wr_addr : rd_addr;

  sp_ram_core #(
    .DEPTH  (MEM_DEPTH),
    .DATA_W (DATA_SIZE),
    .ADDR_W (MEM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (exec_word[DATA_SIZE-1:0]),
    .rdata (ram_rdata)
  );

  // An edge that cannot execute this cycle is parked in a one-deep slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_d <= 1'b0;
      pend_valid <= 1'b0;
      pend_word  <= '0;
    end else begin
      rx_valid_d <= rx_valid;
      if (accept && (state == RD_FETCH || pend_valid)) begin
        pend_valid <= 1'b1;
        pend_word  <= din;
      end else if (exec_valid) begin
        pend_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr <= '0;
      rd_addr <= '0;
    end else if (exec_valid) begin
      unique case (exec_cmd)
        CMD_WR_ADDR: wr_addr <= exec_addr;
        CMD_WR_DATA: if (AUTO_INC) wr_addr <= addr_next(wr_addr);
        CMD_RD_ADDR: rd_addr <= exec_addr;
        CMD_RD_DATA: if (AUTO_INC) rd_addr <= addr_next(rd_addr);
        default: ;
      endcase
    end
  end

  // The RAM captures rd_addr on the accept edge; its output is moved to dout one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dout     <= '0;
      tx_valid <= 1'b0;
    end else begin
      case (state)
        RD_FETCH: begin
          dout     <= ram_rdata;
          tx_valid <= 1'b1;
          state    <= RD_HOLD;
        end
        default: begin
          if (exec_valid) begin
            tx_valid <= 1'b0;
            state    <= (exec_cmd == CMD_RD_DATA) ? RD_FETCH : IDLE;
          end
        end
      endcase
    end
  end

endmodule
